// File: rtl/image1_downsample2x.sv
`default_nettype none
// ============================================================================
// Module      : image1_downsample2x
// Description : 2x2 box-average downsampler for a raster pixel stream using
//               the SEND/ACK/RDY/COUNT actor token handshake. One output
//               token per 2x2 block, raster order, round-half-up average.
// Revision    : 1.0 - initial release
// ============================================================================
module image1_downsample2x #(
    parameter int IMG_W = 512,
    parameter int IMG_H = 512,
    parameter int DW    = 16
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [DW-1:0] In1_DATA,
    input  logic          In1_SEND,
    input  logic [15:0]   In1_COUNT,
    output logic          In1_ACK,
    output logic [DW-1:0] Out1_DATA,
    output logic          Out1_SEND,
    output logic [15:0]   Out1_COUNT,
    input  logic          Out1_RDY,
    input  logic          Out1_ACK
);

    localparam int c_CW    = $clog2(IMG_W);
    localparam int c_RW    = $clog2(IMG_H);
    localparam int c_LBD   = IMG_W / 2;
    localparam int c_LBW   = (IMG_W > 2) ? $clog2(IMG_W / 2) : 1;

    typedef enum logic [0:0] {
        EVEN_ROW = 1'b0,
        ODD_ROW  = 1'b1
    } state_t;

    state_t              r_state;
    logic [c_CW-1:0]     r_col;
    logic [c_RW-1:0]     r_row;
    logic [DW:0]         r_hsum;
    logic [DW-1:0]       r_out_reg;
    logic                r_out_valid;
    logic [DW:0]         r_linebuf [c_LBD];

    logic                w_stall;
    logic                w_accept;
    logic                w_col_last;
    logic                w_row_last;
    logic                w_load;
    logic [c_LBW-1:0]    w_lb_idx;
    logic [DW:0]         w_lb_rd;
    logic [DW:0]         w_hpair;
    logic [DW+1:0]       w_sum;
    logic [DW+1:0]       w_round;
    logic                w_unused;

    // Handshake: input is held off only while a finished token waits on downstream.
    // Gating with RESET keeps In1_ACK low for the whole reset interval.
    assign w_stall    = r_out_valid & ~Out1_RDY;
    assign In1_ACK    = In1_SEND & ~w_stall & RESET;
    assign w_accept   = In1_ACK;
    assign Out1_SEND  = r_out_valid & Out1_RDY;
    assign Out1_DATA  = r_out_reg;
    assign Out1_COUNT = 16'h0001;

    assign w_col_last = (r_col == c_CW'(IMG_W - 1));
    assign w_row_last = (r_row == c_RW'(IMG_H - 1));

    // Odd column of an odd row completes a 2x2 block.
    assign w_load     = w_accept & r_col[0] & (r_state == ODD_ROW);

    assign w_lb_idx   = c_LBW'(r_col >> 1);
    assign w_lb_rd    = r_linebuf[w_lb_idx];
    assign w_hpair    = r_hsum + (DW + 1)'(In1_DATA);
    assign w_sum      = {1'b0, w_lb_rd} + {1'b0, r_hsum} + {2'b00, In1_DATA};
    assign w_round    = w_sum + (DW + 2)'(2);

    // Inputs that carry no information for this actor, plus discarded rounding bits.
    assign w_unused   = ^{In1_COUNT, Out1_ACK, w_round[1:0]};

    // Raster position counters and row-parity state, advanced on accepted pixels.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_col   <= '0;
            r_row   <= '0;
            r_state <= EVEN_ROW;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col   <= '0;
                r_row   <= w_row_last ? '0 : r_row + 1'b1;
                r_state <= (r_state == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
            end else begin
                r_col   <= r_col + 1'b1;
            end
        end
    end

    // Horizontal partial sum: holds the even-column pixel of the current pair.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_hsum <= '0;
        end else if (w_accept && !r_col[0]) begin
            r_hsum <= {1'b0, In1_DATA};
        end
    end

    // Line buffer of even-row pair sums; contents need no reset.
    always_ff @(posedge CLK) begin
        if (w_accept && r_col[0] && (r_state == EVEN_ROW)) begin
            r_linebuf[w_lb_idx] <= w_hpair;
        end
    end

    // Output token register: reload wins over drain so back-to-back results have no bubble.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_out_reg   <= '0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_reg   <= w_round[DW+1:2];
            r_out_valid <= 1'b1;
        end else if (Out1_SEND) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire
